pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, giving the PC loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: requests a start of execution from IDLE.
REQ-006 SHALL have port if_req_o, output, 1 bit: fetch request valid.
REQ-007 SHALL have port if_addr_o, output, DATA_WIDTH bits: fetch address, always equal to pc_o.
REQ-008 SHALL have port if_ack_i, input, 1 bit: the fetch transfers in any cycle where if_req_o and if_ack_i are both high.
REQ-009 SHALL have port exec_start_o, output, 1 bit: one-cycle pulse telling execute/WB that a fetched instruction is issued.
REQ-010 SHALL have port resolve_valid_i, input, 1 bit: the WB next-PC result is valid.
REQ-011 SHALL have port new_pc_i, input, DATA_WIDTH bits: next PC resolved by WB.
REQ-012 SHALL have port execute_error_i, input, 1 bit: WB reports an undecodable branch.
REQ-013 SHALL have port pc_o, output, DATA_WIDTH bits: current PC.
REQ-014 SHALL have port halt_o, output, 1 bit: high while in state HALT.
REQ-015 SHALL have port cause_o, output, 2 bits: halt cause; 0 NONE, 1 EXEC_ERR, 2 MISALIGN.
REQ-016 SHALL have port retire_cnt_o, output, DATA_WIDTH bits: count of retired instructions.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EXEC and HALT.
REQ-018 SHALL transition IDLE->FETCH on start_i=1; all other inputs SHALL be ignored in IDLE.
REQ-019 SHALL hold if_req_o=1 only in FETCH and keep if_addr_o stable until the handshake completes.
REQ-020 SHALL transition FETCH->EXEC on if_req_o&if_ack_i and assert exec_start_o for exactly the following cycle (the first cycle of EXEC).
REQ-021 SHALL ignore resolve_valid_i while in any state other than EXEC.
REQ-022 SHALL ignore resolve_valid_i during the exec_start_o cycle; the earliest accepted resolve SHALL come one cycle after exec_start_o.
REQ-023 SHALL, in EXEC on resolve_valid_i=1 with execute_error_i=0 and a legal target, load pc_o<=new_pc_i, increment retire_cnt_o, and go to FETCH; the minimum fetch-to-fetch period is therefore 3 cycles.
REQ-024 SHALL, in EXEC on resolve_valid_i=1 with execute_error_i=1, go to HALT with cause_o=1, leave pc_o unchanged (faulting PC) and leave retire_cnt_o unchanged.
REQ-025 SHALL treat HALT as terminal: only rst exits it; start_i SHALL be ignored there.
REQ-026 SHALL let retire_cnt_o wrap modulo 2^DATA_WIDTH without raising any flag.
REQ-027 SHALL hold cause_o=0 in every state except HALT.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, force state=IDLE, pc_o=RESET_PC, retire_cnt_o=0, cause_o=0, if_req_o=0, exec_start_o=0 and halt_o=0.
REQ-029 SHALL give rst priority over every other input, including a handshake or resolve in the same cycle.
REQ-030 SHALL abandon any fetch or execute in flight when rst is asserted, without pulsing exec_start_o.

Configuration
REQ-031 SHALL, when PC_ALIGN_CHECK_EN is defined, treat a resolve with new_pc_i[1:0]!=0 as HALT with cause_o=2 and pc_o unchanged.
REQ-032 SHALL give execute_error_i priority over the misalignment check.
REQ-033 SHALL, when PC_ALIGN_CHECK_EN is undefined, load new_pc_i with bits [1:0] forced to 0, never produce cause 2, and retire normally.

Structure
REQ-034 SHALL place the FSM state enum, the cause codes (NONE/EXEC_ERR/MISALIGN) and the default RESET_PC in the shared package pipe_pkg.
REQ-035 SHALL implement retire_cnt_o in a sub-module named retire_counter, with ports clk, rst, inc_i and cnt_o.

Verification
REQ-036 SHALL verify reset then start: rst for 2 cycles, then start_i=1 -> if_req_o=1 and if_addr_o=0x80000000 on the next cycle.
REQ-037 SHALL verify straight-line execution: ack, then resolve with new_pc_i=0x80000004 -> pc_o=0x80000004, retire_cnt_o=1 and if_req_o=1 again.
REQ-038 SHALL verify error handling: resolve with execute_error_i=1 at pc 0x80000010 -> halt_o=1, cause_o=1, pc_o=0x80000010, and start_i afterwards is ignored.
REQ-039 SHALL verify misalignment: new_pc_i=0x80000006 -> cause_o=2 when the macro is defined; pc_o=0x80000004 and retire_cnt_o incremented when undefined.
REQ-040 SHALL verify reset mid-operation: rst together with if_ack_i in FETCH -> no exec_start_o pulse, state IDLE, pc_o=RESET_PC.
REQ-041 SHALL verify counter wrap: preload retire_cnt_o to 2^64-1 via hierarchical force and retire one instruction -> retire_cnt_o=0 with no halt.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the PC sequencer: FSM states, halt cause codes and the default reset PC.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXEC_ERR = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps silently modulo 2^WIDTH.
module retire_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = inc_i ? cnt_q + WIDTH'(1) : cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer: IDLE -> FETCH -> EXEC loop until an error halts it.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned resolved targets into a MISALIGN halt.
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  if_req_o,
    output logic [DATA_WIDTH-1:0] if_addr_o,
    input  logic                  if_ack_i,
    output logic                  exec_start_o,
    input  logic                  resolve_valid_i,
    input  logic [DATA_WIDTH-1:0] new_pc_i,
    input  logic                  execute_error_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  halt_o,
    output logic [1:0]            cause_o,
    output logic [DATA_WIDTH-1:0] retire_cnt_o
);

    state_e                state_q, state_d;
    cause_e                cause_q, cause_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  exec_start_q, exec_start_d;
    logic                  retire_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cause_q      <= CAUSE_NONE;
            pc_q         <= RESET_PC;
            exec_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            pc_q         <= pc_d;
            exec_start_q <= exec_start_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        exec_start_d = 1'b0;
        retire_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (if_ack_i) begin
                    state_d      = ST_EXEC;
                    exec_start_d = 1'b1;
                end
            end
            ST_EXEC: begin
                // The issue cycle itself never accepts a resolve.
                if (resolve_valid_i && !exec_start_q) begin
                    if (execute_error_i) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_EXEC_ERR;
`ifdef PC_ALIGN_CHECK_EN
                    end else if (new_pc_i[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_MISALIGN;
`endif
                    end else begin
                        state_d    = ST_FETCH;
                        pc_d       = {new_pc_i[DATA_WIDTH-1:2], 2'b00};
                        retire_inc = 1'b1;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if_req_o     = (state_q == ST_FETCH);
        halt_o       = (state_q == ST_HALT);
        cause_o      = (state_q == ST_HALT) ? cause_q : CAUSE_NONE;
        exec_start_o = exec_start_q;
        if_addr_o    = pc_q;
        pc_o         = pc_q;
    end

    retire_counter #(
        .WIDTH (DATA_WIDTH)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (retire_inc),
        .cnt_o (retire_cnt_o)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow PC_ALIGN_CHECK_EN when defined.
module tb_pc_sequencer;

    localparam int          W        = 64;
    localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic         if_req_o;
    logic [W-1:0] if_addr_o;
    logic         if_ack_i = 1'b0;
    logic         exec_start_o;
    logic         resolve_valid_i = 1'b0;
    logic [W-1:0] new_pc_i = '0;
    logic         execute_error_i = 1'b0;
    logic [W-1:0] pc_o;
    logic         halt_o;
    logic [1:0]   cause_o;
    logic [W-1:0] retire_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .if_req_o        (if_req_o),
        .if_addr_o       (if_addr_o),
        .if_ack_i        (if_ack_i),
        .exec_start_o    (exec_start_o),
        .resolve_valid_i (resolve_valid_i),
        .new_pc_i        (new_pc_i),
        .execute_error_i (execute_error_i),
        .pc_o            (pc_o),
        .halt_o          (halt_o),
        .cause_o         (cause_o),
        .retire_cnt_o    (retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full instruction: handshake, issue cycle, then resolve.
    task automatic run_instr(input logic [W-1:0] target, input logic err);
        if_ack_i = 1'b1;
        step();
        check("issue_pulse", W'(exec_start_o), W'(1));
        if_ack_i = 1'b0;
        step();
        check("issue_pulse_end", W'(exec_start_o), W'(0));
        resolve_valid_i = 1'b1;
        new_pc_i        = target;
        execute_error_i = err;
        step();
        resolve_valid_i = 1'b0;
        execute_error_i = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles.
        step();
        step();
        check("rst_pc", pc_o, RST_PC);
        check("rst_req", W'(if_req_o), W'(0));
        check("rst_exec", W'(exec_start_o), W'(0));
        check("rst_halt", W'(halt_o), W'(0));
        check("rst_cause", W'(cause_o), W'(0));
        check("rst_retire", retire_cnt_o, W'(0));

        // IDLE ignores everything but start_i.
        rst = 1'b0;
        if_ack_i = 1'b1;
        resolve_valid_i = 1'b1;
        new_pc_i = 64'h1234;
        step();
        check("idle_ignore_req", W'(if_req_o), W'(0));
        check("idle_ignore_pc", pc_o, RST_PC);
        if_ack_i = 1'b0;
        resolve_valid_i = 1'b0;

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("start_req", W'(if_req_o), W'(1));
        check("start_addr", if_addr_o, 64'h8000_0000);

        // FETCH waits for ack with a stable address and ignores resolve.
        resolve_valid_i = 1'b1;
        new_pc_i = 64'h9000_0000;
        step();
        resolve_valid_i = 1'b0;
        check("fetch_hold_req", W'(if_req_o), W'(1));
        check("fetch_hold_addr", if_addr_o, 64'h8000_0000);

        // Resolve during the issue cycle is ignored; accepted one cycle later.
        if_ack_i = 1'b1;
        step();
        if_ack_i = 1'b0;
        check("issue_pulse0", W'(exec_start_o), W'(1));
        check("exec_req_low", W'(if_req_o), W'(0));
        resolve_valid_i = 1'b1;
        new_pc_i = 64'h8000_0004;
        step();
        check("issue_resolve_ignored_pc", pc_o, 64'h8000_0000);
        check("issue_resolve_ignored_cnt", retire_cnt_o, W'(0));
        check("issue_pulse0_end", W'(exec_start_o), W'(0));
        step();
        resolve_valid_i = 1'b0;
        check("straight_pc", pc_o, 64'h8000_0004);
        check("straight_retire", retire_cnt_o, W'(1));
        check("straight_req", W'(if_req_o), W'(1));

        // Misaligned target.
        run_instr(64'h8000_0006, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_halt", W'(halt_o), W'(1));
        check("misalign_cause", W'(cause_o), W'(2));
        check("misalign_pc", pc_o, 64'h8000_0004);
        check("misalign_retire", retire_cnt_o, W'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("misalign_rst_cause", W'(cause_o), W'(0));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
`else
        check("misalign_halt", W'(halt_o), W'(0));
        check("misalign_cause", W'(cause_o), W'(0));
        check("misalign_pc", pc_o, 64'h8000_0004);
        check("misalign_retire", retire_cnt_o, W'(2));
        check("misalign_req", W'(if_req_o), W'(1));
`endif

        run_instr(64'h8000_0010, 1'b0);
        check("to_0x10_pc", pc_o, 64'h8000_0010);
`ifdef PC_ALIGN_CHECK_EN
        check("to_0x10_retire", retire_cnt_o, W'(1));
`else
        check("to_0x10_retire", retire_cnt_o, W'(3));
`endif

        // Error with misaligned target: error wins, cause 1.
        run_instr(64'h8000_0006, 1'b1);
        check("err_halt", W'(halt_o), W'(1));
        check("err_cause", W'(cause_o), W'(1));
        check("err_pc", pc_o, 64'h8000_0010);
        check("err_req", W'(if_req_o), W'(0));
`ifdef PC_ALIGN_CHECK_EN
        check("err_retire", retire_cnt_o, W'(1));
`else
        check("err_retire", retire_cnt_o, W'(3));
`endif
        start_i = 1'b1;
        if_ack_i = 1'b1;
        step();
        step();
        start_i = 1'b0;
        if_ack_i = 1'b0;
        check("halt_sticky", W'(halt_o), W'(1));
        check("halt_sticky_req", W'(if_req_o), W'(0));
        check("halt_sticky_cause", W'(cause_o), W'(1));

        // Reset together with a handshake in FETCH.
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("mid_fetch_req", W'(if_req_o), W'(1));
        rst = 1'b1;
        if_ack_i = 1'b1;
        step();
        rst = 1'b0;
        if_ack_i = 1'b0;
        check("mid_rst_exec", W'(exec_start_o), W'(0));
        check("mid_rst_req", W'(if_req_o), W'(0));
        check("mid_rst_halt", W'(halt_o), W'(0));
        check("mid_rst_pc", pc_o, RST_PC);
        step();
        check("mid_rst_idle_exec", W'(exec_start_o), W'(0));
        check("mid_rst_idle_req", W'(if_req_o), W'(0));

        // Counter wrap: preload all-ones through the counter's next-state.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        force dut.u_retire_counter.cnt_d = '1;
        step();
        release dut.u_retire_counter.cnt_d;
        check("wrap_preload", retire_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(64'h8000_0008, 1'b0);
        check("wrap_cnt", retire_cnt_o, W'(0));
        check("wrap_halt", W'(halt_o), W'(0));
        check("wrap_pc", pc_o, 64'h8000_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
